problem_alu: RTL and testbench
==============================

# problem_alu

Four-function 10-bit ALU with a registered result and a zero flag. It selects pass-A, pass-B, add or subtract under a 2-bit mode code. It is a leaf datapath block driven by a controller that presents operands and mode each cycle. A pipeline valid bit and optional carry/overflow flags accompany the result.

## Interface
Parameters:
- WIDTH, default 10: operand and result width. All behaviour below is stated for WIDTH = 10.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk, input, 1: rising-edge clock for all state.
- rst, input, 1: synchronous, active-high reset.
- a, input, WIDTH: operand A, unsigned.
- b, input, WIDTH: operand B, unsigned.
- mode, input, 2: operation select.
- in_valid, input, 1: operands and mode are valid this cycle.
- y, output, WIDTH: registered result.
- is_zero, output, 1: registered; 1 when y == 0.
- out_valid, output, 1: registered copy of in_valid.
- carry, output, 1: registered carry/borrow flag. Meaningful only with FLAGS; see Configuration.
- overflow, output, 1: registered two's-complement overflow flag. Meaningful only with FLAGS; see Configuration.

## Operation
Mode decode:
- mode 0: y = a.
- mode 1: y = b.
- mode 2: y = (a + b) mod 2^WIDTH.
- mode 3: y = (a − b) mod 2^WIDTH, two's-complement wrap.

Arithmetic and flags:
- Sum and difference use a WIDTH+1-bit intermediate; y keeps the low WIDTH bits.
- is_zero = (next y == 0). It is evaluated on the same value that is loaded into y, for every mode.
- carry: mode 2 gives bit WIDTH of a+b; mode 3 gives 1 when a < b (borrow); modes 0/1 give 0.
- overflow: signed overflow of the add/subtract, treating a and b as two's complement; modes 0/1 give 0.

Register update rules:
- in_valid = 1: y, is_zero, carry and overflow load the new result.
- in_valid = 0: y, is_zero, carry and overflow hold their previous values.
- out_valid follows in_valid every cycle.
- Block is fully pipelined: one new operation is accepted per cycle, with no back-pressure.

## Timing
- Latency: 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N.
- Throughput: 1 operation per clock.
- Reset: on a rising edge with rst = 1, outputs go to y = 0, is_zero = 1, out_valid = 0, carry = 0, overflow = 0.
- Reset overrides in_valid on the same edge.
- Reset mid-stream drops the in-flight result. The first post-reset result appears one cycle after in_valid is reasserted.
- A mode change between cycles takes effect on the next edge. No cross-cycle state exists other than the output registers.
- Outputs are glitch-free, driven directly from flops.

## Configuration
- Macro PROBLEM_ALU_FLAGS_EN.
- Defined: carry and overflow are computed as described in Operation.
- Undefined:
  - carry and overflow ports remain present but are tied to 0.
  - The flag logic is not synthesized.
  - y, is_zero and out_valid behave identically to the defined case.

## Test plan
- Exhaustive sweep, i = 0..1022, with a = i, b = 1023 − i, each mode applied with in_valid = 1. After one clock: mode 0 → y = a; mode 1 → y = b; mode 2 → y = 1023; mode 3 → y = (2i − 1023) mod 1024.
- Wrap cases:
  - a = 0, b = 1023, mode 3 → y = 1, carry = 1 (FLAGS).
  - a = 1, b = 1023, mode 2 → y = 0, is_zero = 1, carry = 1.
- Zero flag:
  - a = 0, b = 0, modes 0–3 → y = 0, is_zero = 1.
  - a = 5, b = 5, mode 3 → is_zero = 1.
  - a = 5, b = 4, mode 3 → y = 1, is_zero = 0.
- Hold and valid: present a = 7, mode 0, in_valid = 1, then a = 9 with in_valid = 0 → y stays 7, out_valid goes 1 then 0.
- Reset: assert rst while in_valid = 1, a = 300, mode 0 → next cycle y = 0, is_zero = 1, out_valid = 0. Deassert rst → next operation completes with 1-cycle latency.
- Overflow (FLAGS): a = 511, b = 1, mode 2 → y = 512, overflow = 1. Without the macro → overflow = 0, carry = 0.

Source files
------------

// File: rtl/problem_alu.sv
// rtl/problem_alu.sv - registered four-function ALU with zero flag and optional carry/overflow (PROBLEM_ALU_FLAGS_EN)
module problem_alu #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             is_zero,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow
);

    localparam logic [1:0] MODE_PASS_A = 2'd0;
    localparam logic [1:0] MODE_PASS_B = 2'd1;
    localparam logic [1:0] MODE_ADD    = 2'd2;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] y_next;

`ifdef PROBLEM_ALU_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           carry_next;
    logic           overflow_next;

    // The extra top bit of the difference is the borrow, i.e. a < b.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign sum      = sum_ext[WIDTH-1:0];
    assign diff     = diff_ext[WIDTH-1:0];

    always_comb begin
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (mode)
            MODE_PASS_A, MODE_PASS_B: begin
                carry_next    = 1'b0;
                overflow_next = 1'b0;
            end
            MODE_ADD: begin
                carry_next    = sum_ext[WIDTH];
                overflow_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                carry_next    = diff_ext[WIDTH];
                overflow_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (in_valid) begin
            carry    <= carry_next;
            overflow <= overflow_next;
        end
    end
`else
    assign sum      = a + b;
    assign diff     = a - b;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
`endif

    always_comb begin
        y_next = a;
        case (mode)
            MODE_PASS_A: y_next = a;
            MODE_PASS_B: y_next = b;
            MODE_ADD:    y_next = sum;
            default:     y_next = diff;
        endcase
    end

    // Zero flag is derived from the value being loaded so it can never lag y.
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            is_zero   <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y       <= y_next;
                is_zero <= (y_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_problem_alu.sv
// tb/tb_problem_alu.sv - directed-vector bench for problem_alu
module tb_problem_alu;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic             is_zero;
    logic             out_valid;
    logic             carry;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [1:0] mode;
        logic [9:0] exp_y;
        logic       exp_z;
        logic       exp_c;
        logic       exp_v;
    } vec_t;

    vec_t vecs [14];

    problem_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .in_valid  (in_valid),
        .y         (y),
        .is_zero   (is_zero),
        .out_valid (out_valid),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags_exp(input logic c, input logic v, output logic ec, output logic ev);
`ifdef PROBLEM_ALU_FLAGS_EN
        ec = c;
        ev = v;
`else
        ec = 1'b0;
        ev = 1'b0;
        if (c || v) ec = 1'b0;
`endif
    endtask

    initial begin
        logic ec, ev;
        logic [9:0] exp3;

        vecs[0]  = '{10'd0,   10'd1023, 2'd3, 10'd1,   1'b0, 1'b1, 1'b0};
        vecs[1]  = '{10'd1,   10'd1023, 2'd2, 10'd0,   1'b1, 1'b1, 1'b0};
        vecs[2]  = '{10'd0,   10'd0,    2'd0, 10'd0,   1'b1, 1'b0, 1'b0};
        vecs[3]  = '{10'd0,   10'd0,    2'd1, 10'd0,   1'b1, 1'b0, 1'b0};
        vecs[4]  = '{10'd0,   10'd0,    2'd2, 10'd0,   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{10'd0,   10'd0,    2'd3, 10'd0,   1'b1, 1'b0, 1'b0};
        vecs[6]  = '{10'd5,   10'd5,    2'd3, 10'd0,   1'b1, 1'b0, 1'b0};
        vecs[7]  = '{10'd5,   10'd4,    2'd3, 10'd1,   1'b0, 1'b0, 1'b0};
        vecs[8]  = '{10'd511, 10'd1,    2'd2, 10'd512, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{10'd512, 10'd512,  2'd2, 10'd0,   1'b1, 1'b1, 1'b1};
        vecs[10] = '{10'd512, 10'd1,    2'd3, 10'd511, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{10'd100, 10'd200,  2'd3, 10'd924, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{10'd300, 10'd700,  2'd0, 10'd300, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{10'd300, 10'd700,  2'd1, 10'd700, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        a = '0;
        b = '0;
        mode = 2'd0;
        in_valid = 1'b0;
        step();
        step();
        check("reset_y", int'(y), 0);
        check("reset_is_zero", int'(is_zero), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_carry", int'(carry), 0);
        check("reset_overflow", int'(overflow), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            a = vecs[i].a;
            b = vecs[i].b;
            mode = vecs[i].mode;
            in_valid = 1'b1;
            step();
            flags_exp(vecs[i].exp_c, vecs[i].exp_v, ec, ev);
            check($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].exp_y));
            check($sformatf("vec%0d_is_zero", i), int'(is_zero), int'(vecs[i].exp_z));
            check($sformatf("vec%0d_out_valid", i), int'(out_valid), 1);
            check($sformatf("vec%0d_carry", i), int'(carry), int'(ec));
            check($sformatf("vec%0d_overflow", i), int'(overflow), int'(ev));
        end

        for (int i = 0; i <= 1022; i++) begin
            for (int m = 0; m < 4; m++) begin
                a = 10'(i);
                b = 10'(1023 - i);
                mode = 2'(m);
                in_valid = 1'b1;
                step();
                exp3 = 10'(2 * i + 1);
                case (m)
                    0: check("sweep_pass_a", int'(y), i);
                    1: check("sweep_pass_b", int'(y), 1023 - i);
                    2: check("sweep_add", int'(y), 1023);
                    default: check("sweep_sub", int'(y), int'(exp3));
                endcase
                if ((m == 0 && i == 0) || (m == 3 && 2 * i + 1 == 1024))
                    check("sweep_is_zero", int'(is_zero), 1);
                else if (m == 0 && i == 1)
                    check("sweep_is_zero", int'(is_zero), 0);
            end
        end

        a = 10'd7;
        mode = 2'd0;
        in_valid = 1'b1;
        step();
        check("hold_load_y", int'(y), 7);
        check("hold_load_out_valid", int'(out_valid), 1);
        a = 10'd9;
        in_valid = 1'b0;
        step();
        check("hold_y", int'(y), 7);
        check("hold_out_valid", int'(out_valid), 0);
        check("hold_is_zero", int'(is_zero), 0);
        step();
        check("hold2_y", int'(y), 7);

        a = 10'd511;
        b = 10'd1;
        mode = 2'd2;
        in_valid = 1'b1;
        step();
        a = 10'd0;
        b = 10'd0;
        mode = 2'd1;
        in_valid = 1'b0;
        step();
        flags_exp(1'b0, 1'b1, ec, ev);
        check("hold_flags_y", int'(y), 512);
        check("hold_flags_overflow", int'(overflow), int'(ev));

        a = 10'd300;
        mode = 2'd0;
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        check("rst_mid_y", int'(y), 0);
        check("rst_mid_is_zero", int'(is_zero), 1);
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_overflow", int'(overflow), 0);
        rst = 1'b0;
        step();
        check("post_rst_y", int'(y), 300);
        check("post_rst_out_valid", int'(out_valid), 1);
        check("post_rst_is_zero", int'(is_zero), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
